// File: rtl/e3_to_bcd_mealy.sv
// Serial Excess-3 to BCD Mealy converter with parallel digit capture.
// Define E3_TO_BCD_ERR_CHK_EN to build the illegal-code err flag.
module e3_to_bcd_mealy (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_valid,
  input  logic       d_in,
  output logic       d_out,
  output logic [3:0] bcd_q,
  output logic       bcd_rdy,
  output logic       err
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100,
    S5 = 3'b101,
    S6 = 3'b110,
    SX = 3'b111
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       shift_en;
  logic       last;
  logic [2:0] shift;
  logic [3:0] digit;

  // State register: bit position plus borrow.
  always_ff @(posedge clk) begin
    if (reset) state <= S0;
    else       state <= state_nxt;
  end

  // Next state and Mealy output; serial subtract-3 with borrow.
  always_comb begin
    state_nxt = state;
    d_out     = 1'b0;
    shift_en  = 1'b0;
    last      = 1'b0;
    case (state)
      S0: if (d_valid) begin
        d_out     = ~d_in;
        shift_en  = 1'b1;
        state_nxt = d_in ? S2 : S1;
      end
      S1: if (d_valid) begin
        d_out     = d_in;
        shift_en  = 1'b1;
        state_nxt = S3;
      end
      S2: if (d_valid) begin
        d_out     = ~d_in;
        shift_en  = 1'b1;
        state_nxt = d_in ? S4 : S3;
      end
      S3: if (d_valid) begin
        d_out     = ~d_in;
        shift_en  = 1'b1;
        state_nxt = d_in ? S6 : S5;
      end
      S4: if (d_valid) begin
        d_out     = d_in;
        shift_en  = 1'b1;
        state_nxt = S6;
      end
      S5: if (d_valid) begin
        d_out     = ~d_in;
        last      = 1'b1;
        state_nxt = S0;
      end
      S6: if (d_valid) begin
        d_out     = d_in;
        last      = 1'b1;
        state_nxt = S0;
      end
      default: state_nxt = S0;
    endcase
  end

  assign digit = {d_out, shift};

  // Collect bits 0..2, then load the whole digit on bit 3.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= 3'b000;
      bcd_q   <= 4'b0000;
      bcd_rdy <= 1'b0;
    end else begin
      bcd_rdy <= last;
      if (shift_en) shift <= {d_out, shift[2:1]};
      if (last) begin
        shift <= 3'b000;
        bcd_q <= digit;
      end
    end
  end

`ifdef E3_TO_BCD_ERR_CHK_EN
  // Results 10..15 come only from illegal Excess-3 codes.
  always_ff @(posedge clk) begin
    if (reset)     err <= 1'b0;
    else if (last) err <= digit[3] & (digit[2] | digit[1]);
  end
`else
  assign err = 1'b0;
`endif

endmodule
